mem_port_monitor: RTL

Testbench-side monitor that taps the CPU's instruction and data memory ports (cache-facing read/write/resp protocol) and turns each completed transaction into a single-cycle, registered event record. Its output drives the shadow memory checker's `imem_*`, `dmem_*`, `write`, `wmask` and `wdata` inputs. It also checks the port protocol, raises sticky error flags, and counts transactions. Simulation-only; not synthesised into the CPU.

---
 rtl/mem_mon_pkg.sv | 20 ++
 rtl/mem_port_tracker.sv | 93 +++++++++
 rtl/mem_port_monitor.sv | 124 ++++++++++++
 3 files changed

// File: rtl/mem_mon_pkg.sv
// Shared types and constants for the memory port monitor.
package mem_mon_pkg;

  typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} trk_state_e;

  localparam int ERR_SPURIOUS = 0;
  localparam int ERR_UNSTABLE = 1;
  localparam int ERR_CONFLICT = 2;
  localparam int ERR_TIMEOUT  = 3;

  // Request as seen on the port; mbe/wdata are zeroed for reads so that
  // a whole-struct compare only looks at fields that matter.
  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  mbe;
    logic [31:0] wdata;
    logic        is_write;
  } mem_req_t;

endpackage

// File: rtl/mem_port_tracker.sv
// Per-port request tracker: follows one read/write/resp handshake, reports
// completions combinationally and flags protocol violations as pulses.
module mem_port_tracker
  import mem_mon_pkg::*;
#(
  parameter int TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_read,
  input  logic        i_write,
  input  logic [31:0] i_addr,
  input  logic [3:0]  i_mbe,
  input  logic [31:0] i_wdata,
  input  logic        i_resp,
  input  logic [31:0] i_rdata,
  output logic        o_done,
  output mem_req_t    o_req,
  output logic [31:0] o_rdata,
  output logic        o_spurious,
  output logic        o_unstable,
  output logic        o_conflict,
  output logic        o_timeout
);

  localparam logic [31:0] LIM = 32'(TIMEOUT);

  trk_state_e  r_state, w_state_nxt;
  mem_req_t    r_req, w_live;
  logic [31:0] r_wcnt;
  logic        w_req;

  // Live request; a read+write conflict is treated as a write.
  always_comb begin
    w_req          = i_read | i_write;
    w_live.addr    = i_addr;
    w_live.is_write = i_write;
    w_live.mbe     = i_write ? i_mbe : 4'd0;
    w_live.wdata   = i_write ? i_wdata : 32'd0;
  end

  assign o_rdata    = i_rdata;
  assign o_conflict = i_read & i_write;
  // Counter holds the number of earlier WAIT cycles, so this fires on the TIMEOUT-th one.
  assign o_timeout  = (r_state == WAIT) && ((r_wcnt + 32'd1) >= LIM);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next state, completion and violation detection.
  always_comb begin
    w_state_nxt = r_state;
    o_done      = 1'b0;
    o_req       = w_live;
    o_spurious  = 1'b0;
    o_unstable  = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_req && i_resp) o_done = 1'b1;
        else if (w_req)      w_state_nxt = WAIT;
        else if (i_resp)     o_spurious = 1'b1;
      end
      WAIT: begin
        o_req      = r_req;
        o_unstable = w_req ? (w_live != r_req) : !i_resp;
        if (i_resp) begin
          o_done      = 1'b1;
          w_state_nxt = IDLE;
        end else if (!w_req) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Capture the request on entry to WAIT and run the saturating wait counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_req  <= '0;
      r_wcnt <= '0;
    end else if (r_state == IDLE && w_state_nxt == WAIT) begin
      r_req  <= w_live;
      r_wcnt <= '0;
    end else if (r_state == WAIT && r_wcnt != LIM) begin
      r_wcnt <= r_wcnt + 32'd1;
    end
  end

endmodule

// File: rtl/mem_port_monitor.sv
// Memory port monitor: turns I/D port completions into registered one-cycle
// event records, keeps sticky protocol error flags and transaction counters.
module mem_port_monitor
  import mem_mon_pkg::*;
#(
  parameter int TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_read,
  input  logic [31:0] inst_addr,
  input  logic        inst_resp,
  input  logic [31:0] inst_rdata,
  input  logic        data_read,
  input  logic        data_write,
  input  logic [3:0]  data_mbe,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  input  logic        data_resp,
  input  logic [31:0] data_rdata,
  output logic        imem_valid,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_rdata,
  output logic        dmem_valid,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_rdata,
  output logic        write,
  output logic [3:0]  wmask,
  output logic [31:0] wdata,
  output logic [3:0]  err,
  output logic [31:0] ireq_count,
  output logic [31:0] dread_count,
  output logic [31:0] dwrite_count
);

  logic        w_i_done, w_i_spur, w_i_unst, w_i_conf, w_i_tmo;
  logic        w_d_done, w_d_spur, w_d_unst, w_d_conf, w_d_tmo;
  mem_req_t    w_i_req, w_d_req;
  logic [31:0] w_i_rdata, w_d_rdata;
  logic [3:0]  w_err_set;
  logic        w_unused_i;

  logic        r_imem_valid, r_dmem_valid, r_write;
  logic [31:0] r_imem_addr, r_imem_rdata, r_dmem_addr, r_dmem_rdata, r_wdata;
  logic [3:0]  r_wmask, r_err;
  logic [31:0] r_icnt, r_drcnt, r_dwcnt;

  mem_port_tracker #(.TIMEOUT(TIMEOUT)) u_itrk (
    .clk(clk), .rst(rst),
    .i_read(inst_read), .i_write(1'b0), .i_addr(inst_addr), .i_mbe(4'd0),
    .i_wdata(32'd0), .i_resp(inst_resp), .i_rdata(inst_rdata),
    .o_done(w_i_done), .o_req(w_i_req), .o_rdata(w_i_rdata),
    .o_spurious(w_i_spur), .o_unstable(w_i_unst), .o_conflict(w_i_conf),
    .o_timeout(w_i_tmo)
  );

  mem_port_tracker #(.TIMEOUT(TIMEOUT)) u_dtrk (
    .clk(clk), .rst(rst),
    .i_read(data_read), .i_write(data_write), .i_addr(data_addr), .i_mbe(data_mbe),
    .i_wdata(data_wdata), .i_resp(data_resp), .i_rdata(data_rdata),
    .o_done(w_d_done), .o_req(w_d_req), .o_rdata(w_d_rdata),
    .o_spurious(w_d_spur), .o_unstable(w_d_unst), .o_conflict(w_d_conf),
    .o_timeout(w_d_tmo)
  );

  // The I-port never writes, so these request fields are always zero.
  assign w_unused_i = ^{w_i_req.mbe, w_i_req.wdata, w_i_req.is_write};

  // Merge per-port violation pulses into err bit positions.
  always_comb begin
    w_err_set               = '0;
    w_err_set[ERR_SPURIOUS] = w_i_spur | w_d_spur;
    w_err_set[ERR_UNSTABLE] = w_i_unst | w_d_unst;
    w_err_set[ERR_CONFLICT] = w_i_conf | w_d_conf;
    w_err_set[ERR_TIMEOUT]  = w_i_tmo  | w_d_tmo;
  end

  // Register events (data outputs hold between events), sticky errors, counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_imem_valid <= 1'b0;  r_imem_addr <= '0;  r_imem_rdata <= '0;
      r_dmem_valid <= 1'b0;  r_dmem_addr <= '0;  r_dmem_rdata <= '0;
      r_write      <= 1'b0;  r_wmask     <= '0;  r_wdata      <= '0;
      r_err        <= '0;
      r_icnt       <= '0;    r_drcnt     <= '0;  r_dwcnt      <= '0;
    end else begin
      r_imem_valid <= w_i_done;
      r_dmem_valid <= w_d_done && !w_d_req.is_write;
      r_write      <= w_d_done &&  w_d_req.is_write;
      r_err        <= r_err | w_err_set;
      if (w_i_done) begin
        r_imem_addr  <= w_i_req.addr;
        r_imem_rdata <= w_i_rdata;
        r_icnt       <= r_icnt + 32'd1;
      end
      if (w_d_done) begin
        r_dmem_addr <= w_d_req.addr;
        if (w_d_req.is_write) begin
          r_wmask <= w_d_req.mbe;
          r_wdata <= w_d_req.wdata;
          r_dwcnt <= r_dwcnt + 32'd1;
        end else begin
          r_dmem_rdata <= w_d_rdata;
          r_drcnt      <= r_drcnt + 32'd1;
        end
      end
    end
  end

  assign imem_valid   = r_imem_valid;
  assign imem_addr    = r_imem_addr;
  assign imem_rdata   = r_imem_rdata;
  assign dmem_valid   = r_dmem_valid;
  assign dmem_addr    = r_dmem_addr;
  assign dmem_rdata   = r_dmem_rdata;
  assign write        = r_write;
  assign wmask        = r_wmask;
  assign wdata        = r_wdata;
  assign err          = r_err;
  assign ireq_count   = r_icnt;
  assign dread_count  = r_drcnt;
  assign dwrite_count = r_dwcnt;

endmodule
